// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and address helpers used by the master datapath.
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Data-phase tracking for the beat whose address was accepted last edge.
    typedef struct packed {
        logic vld;
        logic wr;
    } dphase_t;

    function automatic logic is_wrap(input logic [2:0] b);
        return (b == HB_WRAP4) || (b == HB_WRAP8) || (b == HB_WRAP16);
    endfunction

    // Low six address bits of the next wrapping beat; bits above the wrap
    // boundary are preserved, so only the beat index within the window moves.
    function automatic logic [5:0] wrap_low6(input logic [5:0] lo, input logic [2:0] b);
        logic [5:0] r;
        r = lo + 6'd4;
        case (b)
            HB_WRAP4: r = {lo[5:4], lo[3:0] + 4'd4};
            HB_WRAP8: r = {lo[5],   lo[4:0] + 5'd4};
            default:  ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head is shown combinationally.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 32
) (
    input  logic                     HCLK,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW:0]   wptr, rptr;
    logic          empty, do_push, do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot the push lands in, so push-while-full is legal then.
    assign do_push = push && (!full || do_pop);
    assign level   = wptr - rptr;
    assign rdata   = empty ? '0 : mem[rptr[PW-1:0]];

    always_ff @(posedge HCLK or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (do_push) mem[wptr[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ahb_master_datapath.sv
// AHB-Lite master address/data path: tracks HADDR through bursts, feeds HWDATA
// from the write FIFO and captures HRDATA into the read FIFO.
module ahb_master_datapath
    import ahb_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic                          HCLK,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          busy,
    input  logic [AW-1:0]                 start_addr,
    input  logic [2:0]                    burst,
    input  logic [1:0]                    HTRANS,
    input  logic                          HWRITE,
    input  logic                          HREADY,
    input  logic                          HRESP,
    input  logic [DW-1:0]                 HRDATA,
    input  logic                          wr_push,
    input  logic [DW-1:0]                 wr_data,
    input  logic                          rd_pop,
    output logic [AW-1:0]                 HADDR,
    output logic [2:0]                    HBURST,
    output logic [2:0]                    HSIZE,
    output logic [DW-1:0]                 HWDATA,
    output logic [DW-1:0]                 rd_data,
    output logic                          rd_valid,
    output logic                          wfifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   wfifo_level,
    output logic                          err
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    dphase_t       dp;
    logic          start_acc, acc, wr_beat, cap;
    logic          wempty, rfull;
    logic [DW-1:0] whead;
    logic [LW-1:0] rlevel;
    logic [AW-1:0] nxt;
    logic          cross_1k, err_set;

    assign HSIZE     = HSIZE_WORD;
    assign start_acc = start && !busy;
    // An erroring data phase blocks the address phase sampled alongside it.
    assign acc       = HREADY && !HRESP && ((HTRANS == HT_NONSEQ) || (HTRANS == HT_SEQ));
    assign wr_beat   = acc && HWRITE;
    assign cap       = HREADY && !HRESP && dp.vld && !dp.wr;
    assign wempty    = (wfifo_level == '0);
    assign rd_valid  = (rlevel != '0);

    assign nxt      = is_wrap(HBURST) ? {HADDR[AW-1:6], wrap_low6(HADDR[5:0], HBURST)}
                                      : HADDR + AW'(4);
    assign cross_1k = !is_wrap(HBURST) && (nxt[10] != HADDR[10]);

    always_comb begin
        err_set = 1'b0;
        if (HREADY && HRESP)           err_set = 1'b1;
        if (wr_beat && wempty)         err_set = 1'b1;
        if (cap && rfull && !rd_pop)   err_set = 1'b1;
        if (acc && cross_1k)           err_set = 1'b1;
    end

    always_ff @(posedge HCLK or posedge rst) begin
        if (rst) begin
            HADDR  <= '0;
            HBURST <= HB_SINGLE;
            HWDATA <= '0;
            dp     <= '0;
            err    <= 1'b0;
        end else begin
            if (start_acc) begin
                HADDR  <= start_addr;
                HBURST <= burst;
            end else if (acc) begin
                HADDR  <= nxt;
            end
            if (HREADY) dp <= '{vld: acc, wr: HWRITE};
            if (wr_beat) HWDATA <= wempty ? '0 : whead;
            err <= (err && !start_acc) || err_set;
        end
    end

    sync_fifo #(.DEPTH(FIFO_DEPTH), .DW(DW)) u_wfifo (
        .HCLK  (HCLK),
        .rst   (rst),
        .push  (wr_push),
        .pop   (wr_beat),
        .wdata (wr_data),
        .rdata (whead),
        .full  (wfifo_full),
        .level (wfifo_level)
    );

    sync_fifo #(.DEPTH(FIFO_DEPTH), .DW(DW)) u_rfifo (
        .HCLK  (HCLK),
        .rst   (rst),
        .push  (cap),
        .pop   (rd_pop),
        .wdata (HRDATA),
        .rdata (rd_data),
        .full  (rfull),
        .level (rlevel)
    );

endmodule
